// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the MIPS 5-stage pipeline hazard logic.
// Covers register/Tnew widths, forwarding-select encodings and scoreboard entries.
package mips_pipe_pkg;

    localparam int REG_W = 5;
    localparam int T_W   = 2;

    // A Tuse of 3 means the operand is never read.
    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    localparam logic [T_W-1:0] TNEW_LINK = 2'd0;
    localparam logic [T_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [T_W-1:0] TNEW_LOAD = 2'd2;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_W-1:0] a3;
        logic [T_W-1:0]   tnew;
    } sb_entry_t;

    // One pipeline step closer to the result; saturates at 0 instead of wrapping.
    function automatic logic [T_W-1:0] tnew_age(input logic [T_W-1:0] tnew);
        return (tnew == '0) ? '0 : tnew - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage operand/destination info going in, stall and forwarding controls coming out.
// The pipeline drives through master; the scoreboard consumes through slave.
interface hazard_scoreboard_if;

    logic [mips_pipe_pkg::REG_W-1:0] rs_D;
    logic [mips_pipe_pkg::T_W-1:0]   rs_tuse_D;
    logic [mips_pipe_pkg::REG_W-1:0] rt_D;
    logic [mips_pipe_pkg::T_W-1:0]   rt_tuse_D;
    logic [mips_pipe_pkg::REG_W-1:0] a3_D;
    logic [mips_pipe_pkg::T_W-1:0]   tnew_D;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_flush;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;

    modport master (
        output rs_D, rs_tuse_D, rt_D, rt_tuse_D, a3_D, tnew_D,
        input  pc_en, ifid_en, idex_flush, fwd_rs_D, fwd_rt_D
    );

    modport slave (
        input  rs_D, rs_tuse_D, rt_D, rt_tuse_D, a3_D, tnew_D,
        output pc_en, ifid_en, idex_flush, fwd_rs_D, fwd_rt_D
    );

endinterface

// File: rtl/hazard_operand_check.sv
// Tuse/Tnew hazard check for one D-stage source operand against the E/M/W scoreboard.
// The nearest matching stage decides both the stall and the forwarding source.
module hazard_operand_check
    import mips_pipe_pkg::*;
(
    input  logic [REG_W-1:0] reg_idx,
    input  logic [T_W-1:0]   tuse,
    input  sb_entry_t        e,
    input  sb_entry_t        m,
    input  logic [REG_W-1:0] w_a3,
    output logic             stall,
    output fwd_sel_e         fwd
);

    logic used;
    logic hit_e;
    logic hit_m;
    logic hit_w;

    // $0 is hard-wired, so it can never be produced by an in-flight instruction.
    assign used  = (tuse != TUSE_NONE) && (reg_idx != '0);
    assign hit_e = used && (e.a3 == reg_idx);
    assign hit_m = used && (m.a3 == reg_idx);
    assign hit_w = used && (w_a3 == reg_idx);

    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    always_comb begin
        stall = 1'b0;
        fwd   = FWD_RF;
        if (hit_e) begin
            stall = (e.tnew > tuse);
            if (e.tnew == '0) fwd = FWD_E;
        end else if (hit_m) begin
            stall = (m.tnew > tuse);
            if (m.tnew == '0) fwd = FWD_M;
        end else if (hit_w) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Central stall/forward controller: shadows the E/M/W destination registers and their Tnew,
// drives PC/IF-ID enables and the ID/EX flush, and picks D-stage forwarding sources.
module hazard_scoreboard
    import mips_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   d
);

    sb_entry_t        e_q;
    sb_entry_t        m_q;
    logic [REG_W-1:0] w_a3_q;

    logic     stall_rs;
    logic     stall_rt;
    logic     stall;
    fwd_sel_e fwd_rs;
    fwd_sel_e fwd_rt;

    hazard_operand_check u_rs_check (
        .reg_idx (d.rs_D),
        .tuse    (d.rs_tuse_D),
        .e       (e_q),
        .m       (m_q),
        .w_a3    (w_a3_q),
        .stall   (stall_rs),
        .fwd     (fwd_rs)
    );

    hazard_operand_check u_rt_check (
        .reg_idx (d.rt_D),
        .tuse    (d.rt_tuse_D),
        .e       (e_q),
        .m       (m_q),
        .w_a3    (w_a3_q),
        .stall   (stall_rt),
        .fwd     (fwd_rt)
    );

    assign stall = stall_rs | stall_rt;

    assign d.pc_en      = ~stall;
    assign d.ifid_en    = ~stall;
    assign d.idex_flush = stall;
    assign d.fwd_rs_D   = fwd_rs;
    assign d.fwd_rt_D   = fwd_rt;

    // A stalled D instruction is replaced by a bubble in E, exactly like the ID/EX flush.
    // NOTE: state uses non-blocking assignments so every stage shifts from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_a3_q <= '0;
        end else begin
            w_a3_q    <= m_q.a3;
            m_q.a3    <= e_q.a3;
            m_q.tnew  <= tnew_age(e_q.tnew);
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q.a3   <= d.a3_D;
                e_q.tnew <= d.tnew_D;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus randomized
// instruction streams compared against an age-based model of in-flight instructions.
module tb_hazard_scoreboard;
    import mips_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_scoreboard_if bus ();

    hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .d     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: slot 0 = E, 1 = M, 2 = W. Each slot remembers the destination and the Tnew the
    // instruction had when it entered E; its remaining latency is that value minus its age.
    int md_a3 [3];
    int md_t0 [3];

    function automatic int remaining(input int s);
        return (md_t0[s] > s) ? md_t0[s] - s : 0;
    endfunction

    function automatic void model_op(input int r, input int tuse, output bit st, output int fwd);
        st  = 1'b0;
        fwd = 0;
        if (r == 0 || tuse == 3) return;
        for (int s = 0; s < 3; s++) begin
            if (md_a3[s] == r) begin
                st  = remaining(s) > tuse;
                fwd = (remaining(s) == 0) ? s + 1 : 0;
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        bit s_rs, s_rt;
        int f_rs, f_rt;
        model_op(int'(bus.rs_D), int'(bus.rs_tuse_D), s_rs, f_rs);
        model_op(int'(bus.rt_D), int'(bus.rt_tuse_D), s_rt, f_rt);
        return s_rs | s_rt;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            md_a3[s] = 0;
            md_t0[s] = 0;
        end
    endtask

    task automatic set_d(input int rs, input int rs_tuse, input int rt, input int rt_tuse,
                         input int a3, input int tnew);
        bus.rs_D      = REG_W'(rs);
        bus.rs_tuse_D = T_W'(rs_tuse);
        bus.rt_D      = REG_W'(rt);
        bus.rt_tuse_D = T_W'(rt_tuse);
        bus.a3_D      = REG_W'(a3);
        bus.tnew_D    = T_W'(tnew);
        #1;
    endtask

    task automatic tick();
        bit st;
        st = model_stall();
        @(posedge clk);
        md_a3[2] = md_a3[1];
        md_t0[2] = md_t0[1];
        md_a3[1] = md_a3[0];
        md_t0[1] = md_t0[0];
        md_a3[0] = st ? 0 : int'(bus.a3_D);
        md_t0[0] = st ? 0 : int'(bus.tnew_D);
        #1;
    endtask

    task automatic do_reset();
        set_d(0, 3, 0, 3, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        set_d(8, 0, 0, 3, 8, TNEW_LOAD);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
                n_bad++;
                $display("FAIL reset_ctl[%0d]: got %b want 110", i, {bus.pc_en, bus.ifid_en, bus.idex_flush});
            end
            n_cmp++;
            if (bus.fwd_rs_D !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_fwd_rs[%0d]: got %0d want 0", i, bus.fwd_rs_D);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_release_ctl: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(0, 3, 0, 3, 8, TNEW_LOAD);
        tick();
        set_d(8, 1, 0, 3, 9, TNEW_ALU);
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b001) begin
            n_bad++;
            $display("FAIL load_use_stall: got %b want 001", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        tick();
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL load_use_release: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        n_cmp++;
        if (bus.fwd_rs_D !== 2'd0) begin
            n_bad++;
            $display("FAIL load_use_fwd_m_busy: got %0d want 0", bus.fwd_rs_D);
        end
        tick();
        n_cmp++;
        if (bus.fwd_rs_D !== 2'd3) begin
            n_bad++;
            $display("FAIL load_use_fwd_w: got %0d want 3", bus.fwd_rs_D);
        end
    endtask

    task automatic test_branch_alu();
        do_reset();
        set_d(0, 3, 0, 3, 9, TNEW_ALU);
        tick();
        set_d(9, 0, 0, 3, 0, 0);
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b001) begin
            n_bad++;
            $display("FAIL branch_alu_stall: got %b want 001", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        tick();
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL branch_alu_release: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        n_cmp++;
        if (bus.fwd_rs_D !== 2'd2) begin
            n_bad++;
            $display("FAIL branch_alu_fwd: got %0d want 2", bus.fwd_rs_D);
        end
    endtask

    task automatic test_link_forward();
        do_reset();
        set_d(0, 3, 0, 3, 31, TNEW_LINK);
        tick();
        set_d(31, 0, 0, 3, 0, 0);
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL link_no_stall: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        n_cmp++;
        if (bus.fwd_rs_D !== 2'd1) begin
            n_bad++;
            $display("FAIL link_fwd_e: got %0d want 1", bus.fwd_rs_D);
        end
        tick();
        n_cmp++;
        if (bus.fwd_rs_D !== 2'd2) begin
            n_bad++;
            $display("FAIL link_fwd_m: got %0d want 2", bus.fwd_rs_D);
        end
    endtask

    task automatic test_zero_precedence();
        do_reset();
        set_d(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush, bus.fwd_rs_D, bus.fwd_rt_D} !== 7'b110_00_00) begin
            n_bad++;
            $display("FAIL zero_reg: got %b want 1100000",
                     {bus.pc_en, bus.ifid_en, bus.idex_flush, bus.fwd_rs_D, bus.fwd_rt_D});
        end
        set_d(0, 3, 0, 3, 5, TNEW_LINK);
        tick();
        tick();
        set_d(0, 3, 5, 0, 0, 0);
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL prec_e_over_m_ctl: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        n_cmp++;
        if (bus.fwd_rt_D !== 2'd1) begin
            n_bad++;
            $display("FAIL prec_e_over_m_fwd: got %0d want 1", bus.fwd_rt_D);
        end
        do_reset();
        set_d(0, 3, 0, 3, 5, TNEW_LINK);
        tick();
        set_d(0, 3, 0, 3, 5, TNEW_ALU);
        tick();
        set_d(0, 3, 5, 2, 0, 0);
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL prec_e_busy_ctl: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        n_cmp++;
        if (bus.fwd_rt_D !== 2'd0) begin
            n_bad++;
            $display("FAIL prec_e_busy_fwd: got %0d want 0", bus.fwd_rt_D);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_d(0, 3, 0, 3, 8, TNEW_LOAD);
        tick();
        set_d(8, 1, 0, 3, 0, 0);
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b001) begin
            n_bad++;
            $display("FAIL mid_stall_setup: got %b want 001", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_stall_async_clear: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_stall_after_release: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
        tick();
        n_cmp++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_stall_next_cycle: got %b want 110", {bus.pc_en, bus.ifid_en, bus.idex_flush});
        end
    endtask

    task automatic test_random();
        bit s_rs, s_rt, st;
        int f_rs, f_rt;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            model_op(int'(bus.rs_D), int'(bus.rs_tuse_D), s_rs, f_rs);
            model_op(int'(bus.rt_D), int'(bus.rt_tuse_D), s_rt, f_rt);
            st = s_rs | s_rt;
            n_cmp++;
            if ({bus.pc_en, bus.ifid_en, bus.idex_flush} !== (st ? 3'b001 : 3'b110)) begin
                n_bad++;
                $display("FAIL rand_ctl[%0d]: got %b want %b", i,
                         {bus.pc_en, bus.ifid_en, bus.idex_flush}, (st ? 3'b001 : 3'b110));
            end
            if (!st) begin
                n_cmp++;
                if (bus.fwd_rs_D !== 2'(f_rs)) begin
                    n_bad++;
                    $display("FAIL rand_fwd_rs[%0d]: got %0d want %0d", i, bus.fwd_rs_D, f_rs);
                end
                n_cmp++;
                if (bus.fwd_rt_D !== 2'(f_rt)) begin
                    n_bad++;
                    $display("FAIL rand_fwd_rt[%0d]: got %0d want %0d", i, bus.fwd_rt_D, f_rt);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_alu();
        test_link_forward();
        test_zero_precedence();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
